// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/interrupt sequencer.
package trap_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;

  // mcause interrupt flag position for the default 64-bit datapath
  localparam int MCAUSE_INT_BIT = 63;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_TRAP = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_REDIR = 2'd2,
    ST_DRAIN = 2'd3
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-stage, CSR-file and front-end signals seen by the trap sequencer.
interface trap_ctrl_if #(parameter int XLEN = 64) ();
  import trap_pkg::*;

  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic [1:0]      priv;
  logic            mstatus_mie;
  logic [XLEN-1:0] mie;
  logic            irq_meip;
  logic            irq_msip;
  logic            irq_mtip;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            csr_req;
  trap_kind_t      csr_kind;
  logic [XLEN-1:0] csr_cause;
  logic [XLEN-1:0] csr_epc;
  logic [XLEN-1:0] csr_tval;
  logic            csr_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            stall;
  logic            all_ready;
  logic            busy;

  modport slave (
    input  commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_valid,
           priv, mstatus_mie, mie, irq_meip, irq_msip, irq_mtip, mtvec, mepc,
           csr_ack, all_ready,
    output csr_req, csr_kind, csr_cause, csr_epc, csr_tval,
           redirect_valid, redirect_pc, flush, stall, busy
  );

  modport master (
    output commit_valid, commit_pc, exc_valid, exc_cause, exc_tval, mret_valid,
           priv, mstatus_mie, mie, irq_meip, irq_msip, irq_mtip, mtvec, mepc,
           csr_ack, all_ready,
    input  csr_req, csr_kind, csr_cause, csr_epc, csr_tval,
           redirect_valid, redirect_pc, flush, stall, busy
  );

endinterface

// File: rtl/trap_ctrl_irq_select.sv
// Picks the highest-priority enabled machine interrupt (MEI > MSI > MTI).
module irq_select
  import trap_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            irq_meip,
  input  logic            irq_msip,
  input  logic            irq_mtip,
  input  logic [XLEN-1:0] mie,
  input  logic [1:0]      priv,
  input  logic            mstatus_mie,
  output logic            irq_take,
  output logic [3:0]      irq_code
);

  logic global_en;
  logic mei;
  logic msi;
  logic mti;
  logic unused_mie;

  // Below M mode, machine interrupts are always globally enabled
  assign global_en  = (priv != PRIV_M) || mstatus_mie;
  assign mei        = irq_meip && mie[IRQ_MEI];
  assign msi        = irq_msip && mie[IRQ_MSI];
  assign mti        = irq_mtip && mie[IRQ_MTI];
  assign unused_mie = ^mie;

  always_comb begin
    irq_take = 1'b0;
    irq_code = 4'd0;
    if (global_en) begin
      if (mei) begin
        irq_take = 1'b1;
        irq_code = IRQ_MEI;
      end else if (msi) begin
        irq_take = 1'b1;
        irq_code = IRQ_MSI;
      end else if (mti) begin
        irq_take = 1'b1;
        irq_code = IRQ_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exception/mret/interrupt, commands the CSR file,
// then redirects/flushes once and holds the pipeline until it drains.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit VEC_EN = 1'b1
) (
  input logic        clk,
  input logic        reset,
  trap_ctrl_if.slave bus
);

  trap_state_t     state;
  trap_kind_t      kind_q;
  logic            req_q;
  logic            redir_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic            evt;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] rpc;
  logic            unused_mepc;

  irq_select #(.XLEN(XLEN)) u_irq_select (
    .irq_meip    (bus.irq_meip),
    .irq_msip    (bus.irq_msip),
    .irq_mtip    (bus.irq_mtip),
    .mie         (bus.mie),
    .priv        (bus.priv),
    .mstatus_mie (bus.mstatus_mie),
    .irq_take    (irq_take),
    .irq_code    (irq_code)
  );

  assign evt = bus.exc_valid || bus.mret_valid || (bus.commit_valid && irq_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      kind_q  <= KIND_NONE;
      req_q   <= 1'b0;
      redir_q <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (evt) begin
            state <= ST_CMD;
            req_q <= 1'b1;
            if (bus.exc_valid) begin
              kind_q  <= KIND_TRAP;
              cause_q <= XLEN'(bus.exc_cause);
              epc_q   <= bus.commit_pc;
              tval_q  <= bus.exc_tval;
            end else if (bus.mret_valid) begin
              kind_q  <= KIND_MRET;
              cause_q <= '0;
              epc_q   <= '0;
              tval_q  <= '0;
            end else begin
              kind_q  <= KIND_TRAP;
              cause_q <= {1'b1, (XLEN-1)'(irq_code)};
              epc_q   <= bus.commit_pc;
              tval_q  <= '0;
            end
          end
        end
        ST_CMD: begin
          if (bus.csr_ack) begin
            state   <= ST_REDIR;
            req_q   <= 1'b0;
            redir_q <= 1'b1;
          end
        end
        ST_REDIR: begin
          state   <= ST_DRAIN;
          redir_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (bus.all_ready) begin
            state   <= ST_IDLE;
            kind_q  <= KIND_NONE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Target is built from live mtvec/mepc so it reflects the CSR update just acked
  always_comb begin
    base = {bus.mtvec[XLEN-1:2], 2'b00};
    rpc  = '0;
    if (redir_q) begin
      if (kind_q == KIND_MRET)
        rpc = {bus.mepc[XLEN-1:2], 2'b00};
      else if (VEC_EN && cause_q[XLEN-1] && (bus.mtvec[1:0] == 2'b01))
        rpc = base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
      else
        rpc = base;
    end
  end

  assign unused_mepc        = ^bus.mepc[1:0];
  assign bus.csr_req        = req_q;
  assign bus.csr_kind       = kind_q;
  assign bus.csr_cause      = cause_q;
  assign bus.csr_epc        = epc_q;
  assign bus.csr_tval       = tval_q;
  assign bus.redirect_valid = redir_q;
  assign bus.flush          = redir_q;
  assign bus.redirect_pc    = rpc;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.stall          = reset && ((state != ST_IDLE) || evt);

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap/interrupt sequencer sitting between the memory/commit stage and the CSR register file.
- Arbitrates synchronous exceptions, mret and machine-level interrupts, and commands the CSR file to perform trap entry or trap return.
- After the CSR file acknowledges, issues a pipeline flush and PC redirect, then holds the front end until the pipeline drains.
- Single trap in flight; the pipeline is stalled while busy.

Parameters:
- XLEN, 64, data/PC width.
- VEC_EN, 1, 1 = honour mtvec vectored mode (mtvec[1:0]==1) for interrupts; 0 = always direct.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- commit_valid  in  1  an instruction boundary is visible this cycle.
- commit_pc  in  XLEN  PC of the instruction at that boundary.
- exc_valid  in  1  synchronous exception reported by the memory stage.
- exc_cause  in  4  exception code.
- exc_tval  in  XLEN  faulting value.
- mret_valid  in  1  mret reached the memory stage.
- priv  in  2  current privilege (U=0, S=1, M=3).
- mstatus_mie  in  1  global M interrupt enable.
- mie  in  XLEN  interrupt enable CSR.
- irq_meip, irq_msip, irq_mtip  in  1 each  external, software and timer pending lines.
- mtvec  in  XLEN  trap vector.
- mepc  in  XLEN  return address.
- csr_req  out  1  command to the CSR file.
- csr_kind  out  2  NONE=0, TRAP=1, MRET=2.
- csr_cause  out  XLEN  mcause value; bit XLEN-1 = interrupt.
- csr_epc  out  XLEN  value for mepc.
- csr_tval  out  XLEN  value for mtval.
- csr_ack  in  1  CSR file has applied the command.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  new fetch PC.
- flush  out  1  flush all stages; same cycle as redirect_valid.
- stall  out  1  freeze commit/issue.
- all_ready  in  1  pipeline drained.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0; csr_kind=NONE.
- Source priority, evaluated in IDLE only:
  - exc_valid first.
  - then mret_valid.
  - then interrupt, only if commit_valid.
- Interrupts:
  - Interrupt i is pending when its line is 1 and mie[i] is 1 (MEI=11, MSI=3, MTI=7).
  - Interrupts are globally enabled when priv!=M, or when priv==M and mstatus_mie==1.
  - Interrupt priority: MEI > MSI > MTI.
- FSM states: IDLE, CMD, REDIR, DRAIN.
- IDLE:
  - On a selected event, latch the command registers and go to CMD next cycle, so csr_req rises one cycle after the event is seen.
  - Exception: cause=zero-extended exc_cause, epc=commit_pc, tval=exc_tval.
  - Interrupt: cause={1, code}, tval=0.
  - mret: kind=MRET; cause, epc and tval are 0.
  - Inputs arriving in states other than IDLE are ignored and must be held by the stall.
- CMD:
  - csr_req=1 with all csr_* outputs stable until csr_ack.
  - The cycle csr_ack=1: drop csr_req and go to REDIR.
  - csr_ack while csr_req=0 is ignored.
- REDIR:
  - Exactly one cycle with redirect_valid=1 and flush=1, then go to DRAIN.
  - redirect_pc for TRAP: {mtvec[XLEN-1:2],2'b00}.
  - If VEC_EN, the command is an interrupt and mtvec[1:0]==1: base + 4*code, computed modulo 2^XLEN (wrap-around allowed).
  - redirect_pc for MRET: mepc with bits [1:0] cleared.
  - mtvec and mepc are sampled in the REDIR cycle, i.e. after the CSR update.
- DRAIN: stay until all_ready=1, then go to IDLE. all_ready in the same cycle as REDIR is not observed.
- stall = (state!=IDLE) OR (IDLE AND an event is selected this cycle); combinational.
- Reset asserted mid-sequence (any state): immediate return to IDLE with all outputs cleared. No partial command is re-issued.

Decomposition:
- Shared package trap_pkg:
  - trap_kind_t enum (NONE/TRAP/MRET) and fsm state enum.
  - IRQ code constants IRQ_MEI=11, IRQ_MSI=3, IRQ_MTI=7.
  - MCAUSE_INT_BIT.
  - Reuses the existing PRIV_* constants.
- Sub-module irq_select (combinational):
  - Inputs: pending lines, mie, priv, mstatus_mie.
  - Outputs: irq_take and irq_code[3:0].

Test Plan:
- Exception: exc_valid=1, exc_cause=8, commit_pc=0x8000_0010, priv=U, mtvec=0x8000_0100 -> csr_req next cycle with cause=8, epc=0x8000_0010; ack after 2 cycles -> one-cycle redirect_valid/flush with pc=0x8000_0100; busy until all_ready.
- Timer interrupt: priv=M, mstatus_mie=1, mie[7]=1, irq_mtip=1, commit_valid=1, commit_pc=0x8000_0040 -> cause=0x8000_0000_0000_0007, epc=0x8000_0040; with mtvec=0x8000_0101 and VEC_EN=1, redirect_pc=0x8000_011C.
- Priority/masking:
  - Exception plus pending MEI in the same cycle -> TRAP with the exception cause.
  - MEI and MTI both pending -> code 11.
  - priv=M with mstatus_mie=0 -> no request.
  - priv=U with mstatus_mie=0 -> interrupt taken.
- mret with mepc=0x8000_0203 -> csr_kind=MRET; redirect_pc=0x8000_0200.
- Hold/reset:
  - In CMD, withhold csr_ack for 5 cycles -> outputs stable and stall=1 throughout.
  - Assert reset in DRAIN -> state IDLE, all outputs 0 immediately.
